// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and opcode classification for alu_secuencial.
package alu_pkg;
  localparam logic [3:0] OP_SUMA  = 4'b0001;
  localparam logic [3:0] OP_RESTA = 4'b0010;
  localparam logic [3:0] OP_MUL   = 4'b0011;
  localparam logic [3:0] OP_DIV   = 4'b0100;
  localparam logic [3:0] OP_MOD   = 4'b0101;
  localparam logic [3:0] OP_AND   = 4'b0110;
  localparam logic [3:0] OP_OR    = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_SHL   = 4'b1001;
  localparam logic [3:0] OP_SHR   = 4'b1010;
  localparam logic [3:0] OP_EXP   = 4'b1011;

  typedef enum logic {IDLE, EXEC} estado_t;

  function automatic logic is_iterativa(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD) || (op == OP_EXP);
  endfunction
endpackage

// File: rtl/alu_secuencial_if.sv
// Request/response bundle of alu_secuencial: valid/ready request side and registered result side.
interface alu_secuencial_if #(parameter int N = 8);
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   selector;
  logic [N-1:0] entrada1;
  logic [N-1:0] entrada2;
  logic         out_valid;
  logic [N-1:0] resultado;
  logic         carry;
  logic         cero;
  logic         negativo;
  logic         desbordamiento;
  logic         op_invalida;

  modport slave (
    input  in_valid, selector, entrada1, entrada2,
    output in_ready, out_valid, resultado, carry, cero, negativo, desbordamiento, op_invalida
  );
  modport master (
    output in_valid, selector, entrada1, entrada2,
    input  in_ready, out_valid, resultado, carry, cero, negativo, desbordamiento, op_invalida
  );
endinterface

// File: rtl/div_restaurador.sv
// N-step restoring divider; outputs show the quotient/remainder after the step taken this edge.
module div_restaurador #(parameter int N = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         step,
  input  logic [N-1:0] dividendo,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] cociente,
  output logic [N-1:0] resto
);
  logic [N-1:0] coc_q, coc_d, rem_q, rem_d, den_q, den_d;
  logic [N:0]   parcial, dif;

  always_comb begin
    coc_d   = coc_q;
    rem_d   = rem_q;
    den_d   = den_q;
    parcial = {rem_q, coc_q[N-1]};
    dif     = parcial - {1'b0, den_q};
    if (start) begin
      coc_d = dividendo;
      rem_d = '0;
      den_d = divisor;
    end else if (step) begin
      if (parcial >= {1'b0, den_q}) begin
        rem_d = dif[N-1:0];
        coc_d = {coc_q[N-2:0], 1'b1};
      end else begin
        rem_d = parcial[N-1:0];
        coc_d = {coc_q[N-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coc_q <= '0;
      rem_q <= '0;
      den_q <= '0;
    end else begin
      coc_q <= coc_d;
      rem_q <= rem_d;
      den_q <= den_d;
    end
  end

  // The top level latches results on the final step edge, so it needs the post-step values.
  assign cociente = coc_d;
  assign resto    = rem_d;
endmodule

// File: rtl/alu_secuencial.sv
// Registered N-bit ALU: single-cycle logic/arith ops, iterative mul/div/mod/exp over N edges.
module alu_secuencial
  import alu_pkg::*;
#(parameter int N = 8) (
  input  logic clk,
  input  logic rst_n,
  alu_secuencial_if.slave bus
);
  localparam int CW = $clog2(N + 1);
  localparam int SW = $clog2(N);

  estado_t        estado_q, estado_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [3:0]     op_q, op_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d, exp_q, exp_d;
  logic [2*N-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic           exp_ovf_q, exp_ovf_d, div0_q, div0_d;
  logic [N-1:0]   res_q, res_d;
  logic           carry_q, carry_d, cero_q, cero_d, neg_q, neg_d;
  logic           ovf_q, ovf_d, inv_q, inv_d, out_valid_q, out_valid_d;

  logic [N-1:0]   sc_res, coc_nx, rest_nx;
  logic           sc_carry, sc_neg, sc_ovf, sc_inv, fuera, ultimo;
  logic           aceptar, div_start, div_step;
  logic [N:0]     suma, resta;
  logic [SW-1:0]  sh;
  logic [2*N-1:0] shl_w, shr_w, sq, mx;

  assign aceptar   = bus.in_valid && (estado_q == IDLE);
  assign div_start = aceptar && ((bus.selector == OP_DIV) || (bus.selector == OP_MOD));
  assign div_step  = (estado_q == EXEC) && ((op_q == OP_DIV) || (op_q == OP_MOD));
  assign ultimo    = (estado_q == EXEC) && (cnt_q == CW'(N - 1));

  div_restaurador #(.N(N)) u_div (
    .clk(clk), .rst_n(rst_n), .start(div_start), .step(div_step),
    .dividendo(bus.entrada1), .divisor(bus.entrada2),
    .cociente(coc_nx), .resto(rest_nx)
  );

  // Single-cycle ops work straight off the bus operands on the accepting edge.
  always_comb begin
    sc_res = '0; sc_carry = 1'b0; sc_neg = 1'b0; sc_ovf = 1'b0; sc_inv = 1'b0;
    suma  = {1'b0, bus.entrada1} + {1'b0, bus.entrada2};
    resta = {1'b0, bus.entrada1} - {1'b0, bus.entrada2};
    fuera = (bus.entrada2 >> SW) != '0;
    sh    = bus.entrada2[SW-1:0];
    shl_w = {{N{1'b0}}, bus.entrada1} << sh;
    shr_w = {bus.entrada1, {N{1'b0}}} >> sh;
    case (bus.selector)
      OP_SUMA: begin
        sc_res = suma[N-1:0]; sc_carry = suma[N]; sc_neg = suma[N-1];
        sc_ovf = (bus.entrada1[N-1] == bus.entrada2[N-1]) && (suma[N-1] != bus.entrada1[N-1]);
      end
      OP_RESTA: begin
        sc_res = resta[N-1:0]; sc_carry = resta[N]; sc_neg = resta[N-1];
        sc_ovf = (bus.entrada1[N-1] != bus.entrada2[N-1]) && (resta[N-1] != bus.entrada1[N-1]);
      end
      OP_AND: sc_res = bus.entrada1 & bus.entrada2;
      OP_OR:  sc_res = bus.entrada1 | bus.entrada2;
      OP_XOR: sc_res = bus.entrada1 ^ bus.entrada2;
      // The bit landing just past the kept window is the last one shifted out.
      OP_SHL: if (!fuera) begin sc_res = shl_w[N-1:0];     sc_carry = shl_w[N];   end
      OP_SHR: if (!fuera) begin sc_res = shr_w[2*N-1:N];   sc_carry = shr_w[N-1]; end
      default: sc_inv = !is_iterativa(bus.selector);
    endcase
  end

  always_comb begin
    estado_d = estado_q; cnt_d = cnt_q; op_d = op_q; a_d = a_q; b_d = b_q;
    mcand_d = mcand_q; prod_d = prod_q; exp_d = exp_q; exp_ovf_d = exp_ovf_q; div0_d = div0_q;
    res_d = res_q; carry_d = carry_q; cero_d = cero_q; neg_d = neg_q; ovf_d = ovf_q; inv_d = inv_q;
    out_valid_d = 1'b0;
    sq = {{N{1'b0}}, exp_q} * {{N{1'b0}}, exp_q};
    mx = {{N{1'b0}}, sq[N-1:0]} * {{N{1'b0}}, a_q};
    case (estado_q)
      IDLE: if (bus.in_valid) begin
        op_d = bus.selector; a_d = bus.entrada1; b_d = bus.entrada2;
        if (is_iterativa(bus.selector)) begin
          estado_d = EXEC; cnt_d = '0;
          prod_d = '0; mcand_d = {{N{1'b0}}, bus.entrada1};
          exp_d = {{(N-1){1'b0}}, 1'b1}; exp_ovf_d = 1'b0;
          div0_d = (bus.entrada2 == '0);
        end else begin
          out_valid_d = 1'b1;
          res_d = sc_res; carry_d = sc_carry; neg_d = sc_neg; ovf_d = sc_ovf; inv_d = sc_inv;
        end
      end
      EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          prod_d  = b_q[0] ? prod_q + mcand_q : prod_q;
          mcand_d = mcand_q << 1;
          b_d     = b_q >> 1;
        end
        // Square-and-multiply, exponent scanned MSB-first out of b_q.
        if (op_q == OP_EXP) begin
          exp_d     = b_q[N-1] ? mx[N-1:0] : sq[N-1:0];
          exp_ovf_d = exp_ovf_q || (|sq[2*N-1:N]) || (b_q[N-1] && (|mx[2*N-1:N]));
          b_d       = b_q << 1;
        end
        if (ultimo) begin
          estado_d = IDLE; out_valid_d = 1'b1;
          carry_d = 1'b0; neg_d = 1'b0; ovf_d = 1'b0; inv_d = 1'b0;
          case (op_q)
            OP_MUL: begin
              res_d = prod_d[N-1:0]; carry_d = |prod_d[2*N-1:N]; ovf_d = |prod_d[2*N-1:N];
            end
            OP_DIV:  begin res_d = div0_q ? '1 : coc_nx;  ovf_d = div0_q; end
            OP_MOD:  begin res_d = div0_q ? a_q : rest_nx; ovf_d = div0_q; end
            default: begin res_d = exp_d; carry_d = exp_ovf_d; ovf_d = exp_ovf_d; end
          endcase
        end
      end
      default: estado_d = IDLE;
    endcase
    if (out_valid_d) cero_d = (res_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q <= IDLE; cnt_q <= '0; op_q <= '0; a_q <= '0; b_q <= '0;
      mcand_q <= '0; prod_q <= '0; exp_q <= '0; exp_ovf_q <= 1'b0; div0_q <= 1'b0;
      res_q <= '0; carry_q <= 1'b0; cero_q <= 1'b0; neg_q <= 1'b0;
      ovf_q <= 1'b0; inv_q <= 1'b0; out_valid_q <= 1'b0;
    end else begin
      estado_q <= estado_d; cnt_q <= cnt_d; op_q <= op_d; a_q <= a_d; b_q <= b_d;
      mcand_q <= mcand_d; prod_q <= prod_d; exp_q <= exp_d; exp_ovf_q <= exp_ovf_d; div0_q <= div0_d;
      res_q <= res_d; carry_q <= carry_d; cero_q <= cero_d; neg_q <= neg_d;
      ovf_q <= ovf_d; inv_q <= inv_d; out_valid_q <= out_valid_d;
    end
  end

  // in_ready is gated by rst_n so every output reads 0 while reset is held.
  assign bus.in_ready       = rst_n && (estado_q == IDLE);
  assign bus.out_valid      = out_valid_q;
  assign bus.resultado      = res_q;
  assign bus.carry          = carry_q;
  assign bus.cero           = cero_q;
  assign bus.negativo       = neg_q;
  assign bus.desbordamiento = ovf_q;
  assign bus.op_invalida    = inv_q;
endmodule

// File: tb/tb_alu_secuencial.sv
// Bench for alu_secuencial (N=8): directed plan vectors, randomized ops against a reference model.
module tb_alu_secuencial;
  import alu_pkg::*;
  localparam int N = 8;
  localparam longint unsigned M = (64'd1 << N) - 1;
  localparam longint unsigned H = 64'd1 << (N - 1);

  typedef struct {
    logic [N-1:0] res;
    logic c, z, n, v, inv;
    int lat;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_secuencial_if #(.N(N)) bus ();
  alu_secuencial #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  function automatic longint sval(input longint unsigned x);
    return (x >= H) ? longint'(x) - longint'(2 * H) : longint'(x);
  endfunction

  // Reference model: what each opcode should produce, in plain integer arithmetic.
  function automatic resp_t modelo(input logic [3:0] op, input logic [N-1:0] ai, input logic [N-1:0] bi);
    resp_t e;
    longint unsigned a, b, full, r, p;
    longint s;
    a = longint'(ai); b = longint'(bi);
    e.res = '0; e.c = 0; e.n = 0; e.v = 0; e.inv = 0; e.lat = 1;
    case (op)
      OP_SUMA: begin
        full = a + b; e.res = N'(full); e.c = (full > M);
        s = sval(a) + sval(b); e.v = (s > longint'(H) - 1) || (s < -longint'(H));
        e.n = (full & M) >= H;
      end
      OP_RESTA: begin
        e.res = N'(a - b); e.c = (a < b);
        s = sval(a) - sval(b); e.v = (s > longint'(H) - 1) || (s < -longint'(H));
        e.n = ((a - b) & M) >= H;
      end
      OP_MUL: begin
        full = a * b; e.res = N'(full); e.c = (full > M); e.v = e.c; e.lat = N + 1;
      end
      OP_DIV: begin
        e.lat = N + 1;
        if (b == 0) begin e.res = N'(M); e.v = 1; end else e.res = N'(a / b);
      end
      OP_MOD: begin
        e.lat = N + 1;
        if (b == 0) begin e.res = N'(a); e.v = 1; end else e.res = N'(a % b);
      end
      OP_AND: e.res = N'(a & b);
      OP_OR:  e.res = N'(a | b);
      OP_XOR: e.res = N'(a ^ b);
      OP_SHL: if (b < N) begin
        e.res = N'((a << b) & M); e.c = (b > 0) ? ((a >> (N - b)) & 1) != 0 : 0;
      end
      OP_SHR: if (b < N) begin
        e.res = N'(a >> b); e.c = (b > 0) ? ((a >> (b - 1)) & 1) != 0 : 0;
      end
      OP_EXP: begin
        e.lat = N + 1; r = 1;
        for (int i = N - 1; i >= 0; i--) begin
          p = r * r; if (p > M) e.v = 1; r = p & M;
          if (((b >> i) & 1) != 0) begin p = r * a; if (p > M) e.v = 1; r = p & M; end
        end
        e.res = N'(r); e.c = e.v;
      end
      default: e.inv = 1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  // Issues one request from a #1-after-edge point with the DUT idle; returns what it reports.
  task automatic run_op(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input bit scramble, output resp_t r, output int rdy_low);
    int lat;
    rdy_low = 0;
    bus.selector = op; bus.entrada1 = a; bus.entrada2 = b; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      if (!bus.in_ready) rdy_low++;
      if (scramble) begin
        bus.entrada1 = N'($urandom); bus.entrada2 = N'($urandom);
        bus.selector = 4'($urandom); bus.in_valid = 1'($urandom);
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    r.res = bus.resultado; r.c = bus.carry; r.z = bus.cero; r.n = bus.negativo;
    r.v = bus.desbordamiento; r.inv = bus.op_invalida;
    r.lat = bus.out_valid ? lat : -1;
  endtask

  task automatic test_reset();
    logic [N+7:0] outs;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.selector = '0; bus.entrada1 = '0; bus.entrada2 = '0;
    #23;
    outs = {bus.out_valid, bus.resultado, bus.carry, bus.cero, bus.negativo,
            bus.desbordamiento, bus.op_invalida, bus.in_ready};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", outs); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_release ready=%b valid=%b exp ready=1 valid=0", bus.in_ready, bus.out_valid);
    end
  endtask

  task automatic test_directed();
    logic [3:0] ops [15] = '{OP_SUMA, OP_SUMA, OP_RESTA, OP_RESTA, OP_MUL, OP_DIV, OP_MOD, OP_DIV,
                             OP_MOD, OP_EXP, OP_EXP, OP_EXP, OP_SHL, OP_SHR, 4'b1110};
    logic [N-1:0] as [15] = '{200, 100, 5, 9, 20, 100, 100, 100, 100, 3, 2, 0, 8'h81, 8'h81, 0};
    logic [N-1:0] bs [15] = '{100, 50, 7, 9, 13, 7, 7, 0, 0, 5, 8, 0, 1, 9, 0};
    logic [N-1:0] rs [15] = '{44, 150, 8'hFE, 0, 4, 14, 2, 8'hFF, 100, 243, 0, 1, 8'h02, 0, 0};
    // flags packed as {carry, cero, negativo, desbordamiento, op_invalida}
    logic [4:0]   fs [15] = '{5'b10000, 5'b00110, 5'b10100, 5'b01000, 5'b10010, 5'b00000, 5'b00000,
                             5'b00010, 5'b00010, 5'b00000, 5'b11010, 5'b00000, 5'b10000, 5'b01000, 5'b01001};
    int ls [15] = '{1, 1, 1, 1, 9, 9, 9, 9, 9, 9, 9, 9, 1, 1, 1};
    resp_t g;
    int rl;
    for (int i = 0; i < 15; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, g, rl);
      checks++;
      if (g.res !== rs[i]) begin errors++; $display("FAIL dir%0d_res op=%h got=%h exp=%h", i, ops[i], g.res, rs[i]); end
      checks++;
      if ({g.c, g.z, g.n, g.v, g.inv} !== fs[i]) begin
        errors++; $display("FAIL dir%0d_flags op=%h got=%b exp=%b", i, ops[i], {g.c, g.z, g.n, g.v, g.inv}, fs[i]);
      end
      checks++;
      if (g.lat != ls[i]) begin errors++; $display("FAIL dir%0d_lat op=%h got=%0d exp=%0d", i, ops[i], g.lat, ls[i]); end
    end
  endtask

  task automatic test_mul_hold();
    resp_t g;
    int rl;
    logic [N-1:0] held;
    run_op(OP_MUL, 20, 13, 1'b1, g, rl);
    checks++;
    if (g.res !== 8'd4 || g.c !== 1'b1 || g.v !== 1'b1) begin
      errors++; $display("FAIL mul_scramble got=%h c=%b v=%b exp=04 c=1 v=1", g.res, g.c, g.v);
    end
    checks++;
    if (rl != N) begin errors++; $display("FAIL mul_ready_low got=%0d exp=%0d", rl, N); end
    checks++;
    if (g.lat != N + 1 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL mul_latency got=%0d ready=%b exp=%0d ready=1", g.lat, bus.in_ready, N + 1);
    end
    held = bus.resultado;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.resultado !== 8'd4 || bus.carry !== 1'b1) begin
        errors++; $display("FAIL hold%0d got valid=%b res=%h exp valid=0 res=%h", i, bus.out_valid, bus.resultado, held);
      end
    end
  endtask

  task automatic test_random();
    resp_t g, e;
    int rl;
    logic [3:0] op;
    logic [N-1:0] a, b;
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom);
      a = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
      b = ($urandom_range(0, 2) == 0) ? N'($urandom_range(0, 10)) : N'($urandom);
      e = modelo(op, a, b);
      run_op(op, a, b, 1'b0, g, rl);
      checks++;
      if (g.res !== e.res) begin errors++; $display("FAIL rnd_res op=%h a=%h b=%h got=%h exp=%h", op, a, b, g.res, e.res); end
      checks++;
      if ({g.c, g.z, g.n, g.v, g.inv} !== {e.c, e.z, e.n, e.v, e.inv}) begin
        errors++; $display("FAIL rnd_flags op=%h a=%h b=%h got=%b exp=%b", op, a, b,
                           {g.c, g.z, g.n, g.v, g.inv}, {e.c, e.z, e.n, e.v, e.inv});
      end
      checks++;
      if (g.lat != e.lat) begin errors++; $display("FAIL rnd_lat op=%h got=%0d exp=%0d", op, g.lat, e.lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] singles [10] = '{OP_SUMA, OP_RESTA, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, 4'b0000, 4'b1100, 4'b1111};
    resp_t e;
    logic [3:0] op;
    logic [N-1:0] a, b;
    for (int i = 0; i < 20; i++) begin
      op = singles[$urandom_range(0, 9)];
      a = N'($urandom);
      b = N'($urandom_range(0, 9));
      e = modelo(op, a, b);
      bus.selector = op; bus.entrada1 = a; bus.entrada2 = b; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.resultado !== e.res ||
          {bus.carry, bus.cero, bus.negativo, bus.desbordamiento, bus.op_invalida} !== {e.c, e.z, e.n, e.v, e.inv}) begin
        errors++; $display("FAIL b2b%0d op=%h valid=%b res=%h exp res=%h", i, op, bus.out_valid, bus.resultado, e.res);
      end
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    resp_t g;
    int rl;
    int seen;
    logic [N+7:0] outs;
    run_op(OP_SUMA, 200, 100, 1'b0, g, rl);
    bus.selector = OP_MUL; bus.entrada1 = 20; bus.entrada2 = 13; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    outs = {bus.out_valid, bus.resultado, bus.carry, bus.cero, bus.negativo,
            bus.desbordamiento, bus.op_invalida, bus.in_ready};
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL midreset_outputs got=%h exp=0", outs); end
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", bus.in_ready); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL midreset_no_valid got=%0d exp=0", seen); end
    run_op(4'b1110, 8'h5A, 8'h33, 1'b0, g, rl);
    checks++;
    if (g.res !== '0 || g.inv !== 1'b1 || g.z !== 1'b1 || g.c !== 1'b0 || g.v !== 1'b0 || g.lat != 1) begin
      errors++; $display("FAIL invalid_after_reset res=%h inv=%b cero=%b lat=%0d exp res=0 inv=1 cero=1 lat=1",
                         g.res, g.inv, g.z, g.lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mul_hold();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
- Parametrised, registered, multi-cycle successor to the team's combinational 4-bit ALU.
- Keeps the same 4-bit opcode map and flag set (carry, cero, negativo, desbordamiento), generalised to N-bit operands.
- Adds a valid/ready input handshake, iterative multiply/divide/modulo/exponent, and registered results held until the next completion.
- Sits between the register file / operand muxes and the result bus of the lab datapath.

Parameters:
- N, 8, operand and result width in bits (N >= 4, power of two).
- CW, $clog2(N+1), width of the iteration counter (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  high when a request can be accepted.
- selector  in  4  opcode.
- entrada1  in  N  operand A.
- entrada2  in  N  operand B.
- out_valid  out  1  one-cycle pulse when resultado and the flags update.
- resultado  out  N  registered result.
- carry  out  1  registered carry/borrow/truncation flag.
- cero  out  1  registered flag: resultado == 0.
- negativo  out  1  registered flag: sign of the result.
- desbordamiento  out  1  registered overflow flag.
- op_invalida  out  1  registered flag: unsupported opcode.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset: state IDLE; all outputs 0 except in_ready = 1 once rst_n deasserts; counter cleared.
- Accept: an edge with in_valid && in_ready. selector, entrada1 and entrada2 are captured; later input changes are ignored.
- in_ready = (state == IDLE). in_valid while in EXEC is ignored and not queued.
- States: IDLE and EXEC.
  - Single-cycle ops stay in IDLE. Result and flags register on the accepting edge; out_valid is high the following cycle (latency 1).
  - Back-to-back accepts are allowed, one per cycle.
  - Iterative ops go IDLE->EXEC and run N iteration edges. The last iteration edge writes result and flags and returns to IDLE.
  - out_valid goes high in the first IDLE cycle (latency N+1 edges). in_ready is also high in that cycle.
- Hold: resultado and all flags keep their values until the next out_valid. cero is always computed from the new result.
- Opcodes and flag rules (all arithmetic unsigned unless stated):
  - 0001 add (1 cycle): carry = carry out of bit N-1; desbordamiento = two's-complement overflow; negativo = result[N-1].
  - 0010 sub A-B (1 cycle): carry = borrow (A<B); desbordamiento = signed overflow; negativo = result[N-1].
  - 0011 mul (iterative, shift-add over 2N bits): resultado = low N bits; carry = desbordamiento = (high N bits != 0); negativo = 0.
  - 0100 div (iterative, restoring): resultado = quotient. 0101 mod (same datapath): resultado = remainder.
  - Divide by zero (B==0), latency unchanged: div -> all ones, mod -> A; desbordamiento = 1; carry = 0; negativo = 0.
  - 0110 and, 0111 or, 1000 xor (1 cycle): carry = negativo = desbordamiento = 0.
  - 1001 shl, 1010 shr, logical (1 cycle): shift amount = B. If B >= N, result 0 and carry 0. Otherwise carry = last bit shifted out.
  - 1011 exp A^B mod 2^N (iterative): square-and-multiply scanning B MSB-first, one bit per iteration. 0^0 = 1.
  - Exp flags: carry = desbordamiento = 1 if any intermediate product lost nonzero bits above N; negativo = 0.
  - 0000, 1100-1111: 1 cycle; resultado = 0; op_invalida = 1; cero = 1; other flags 0. op_invalida is 0 for every valid op.
- Reset mid-operation: asynchronous abort to IDLE with outputs cleared. No out_valid is produced for the aborted op.

Decomposition:
- Package alu_pkg: opcode localparams (OP_SUMA ... OP_EXP), state enum {IDLE, EXEC}, helper function is_iterativa(op).
- One sub-module, div_restaurador: N-step restoring divider with start/step inputs and quotient/remainder outputs, shared by div and mod.
- mul and exp stay in the top level.

Test Plan (N=8):
- add 200+100 -> resultado 44, carry 1, desbordamiento 0, negativo 0, out_valid exactly 1 cycle after accept; then add 100+50 -> 150, desbordamiento 1, negativo 1.
- sub 5-7 -> 0xFE, carry 1, negativo 1, desbordamiento 0; sub 9-9 -> 0, cero 1.
- mul 20*13 -> resultado 4, carry 1, desbordamiento 1; in_ready low for 8 cycles; out_valid exactly 9 edges after accept; mid-op changes to entrada1/entrada2 have no effect.
- div 100/7 -> 14; mod 100%7 -> 2; div 100/0 -> 0xFF, desbordamiento 1; mod 100%0 -> 100, desbordamiento 1; all at latency 9.
- exp 3^5 -> 243, carry 0; exp 2^8 -> 0, cero 1, carry 1; exp 0^0 -> 1; shl 0x81 by 1 -> 0x02, carry 1; shr by 9 -> 0.
- Start mul and pull rst_n low at cycle 4 -> all outputs 0 immediately, in_ready 1 after release, no out_valid; then selector 1110 -> resultado 0, op_invalida 1, cero 1.
